mux_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one DEPTH-input mux between DEPTH requesters.
- Each requester presents a BIT_WIDTH word plus a valid flag. The arbiter picks one requester, drives the mux select, and forwards the selected word to a single downstream consumer over a valid/ready handshake.
- A granted requester may hold the grant for up to BURST_LEN beats, then the grant rotates.
- Sits between the requester blocks and the shared mux datapath. Instantiates the existing mux internally (same BIT_WIDTH/DEPTH/SEL_WIDTH).

---
 rtl/mux_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one DEPTH-input mux between DEPTH requesters.
// The grant is held for up to BURST_LEN accepted beats, then it rotates.

module mux #(
   parameter int BIT_WIDTH = 4,
   parameter int DEPTH     = 4,
   parameter int SEL_WIDTH = 2
) (
   input  logic [BIT_WIDTH*DEPTH-1:0] dataIn,
   input  logic [SEL_WIDTH-1:0]       select,
   output logic [BIT_WIDTH-1:0]       muxout
);

   always_comb begin
      muxout = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (select == SEL_WIDTH'(i)) muxout = dataIn[BIT_WIDTH*i +: BIT_WIDTH];
      end
   end

endmodule

module mux_rr_arbiter #(
   parameter int BIT_WIDTH = 4,
   parameter int DEPTH     = 4,
   parameter int SEL_WIDTH = 2,
   parameter int BURST_LEN = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DEPTH-1:0]           reqValid,
   output logic [DEPTH-1:0]           reqReady,
   input  logic [BIT_WIDTH*DEPTH-1:0] dataIn,
   output logic                       outValid,
   input  logic                       outReady,
   output logic [BIT_WIDTH-1:0]       muxout,
   output logic [SEL_WIDTH-1:0]       select,
   output logic                       busy
);

   localparam int                   CNT_W     = $clog2(BURST_LEN) + 1;
   localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(BURST_LEN - 1);
   localparam logic [SEL_WIDTH-1:0] LAST_IDX  = SEL_WIDTH'(DEPTH - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t               state;
   logic [SEL_WIDTH-1:0] pointer;
   logic [SEL_WIDTH-1:0] winner;
   logic [SEL_WIDTH-1:0] next_ptr;
   logic [CNT_W-1:0]     beat_cnt;
   logic                 any_req;
   logic                 transfer;

   // Scan starts at pointer and wraps at DEPTH-1, not at the select range.
   always_comb begin
      int idx;
      winner  = '0;
      any_req = 1'b0;
      idx     = 0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = int'(pointer) + k;
         if (idx >= DEPTH) idx = idx - DEPTH;
         if (!any_req && reqValid[idx]) begin
            winner  = SEL_WIDTH'(idx);
            any_req = 1'b1;
         end
      end
   end

   // Handshake: a beat moves when outValid & outReady are both high in a cycle;
   // the granted requester sees reqReady on exactly that cycle and must hold its
   // word stable until then. Outputs are forced low while rst is high.
   assign outValid = !rst && (state == GRANT) && reqValid[select];
   assign transfer = outValid && outReady;
   assign reqReady = transfer ? (DEPTH'(1) << select) : '0;
   assign next_ptr = (select == LAST_IDX) ? '0 : select + SEL_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         select   <= '0;
         pointer  <= '0;
         beat_cnt <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  select   <= winner;
                  beat_cnt <= '0;
                  state    <= GRANT;
                  busy     <= 1'b1;
               end
            end
            GRANT: begin
               if (!reqValid[select]) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  pointer  <= next_ptr;
                  beat_cnt <= '0;
               end else if (outReady) begin
                  if (beat_cnt == LAST_BEAT) begin
                     state    <= IDLE;
                     busy     <= 1'b0;
                     pointer  <= next_ptr;
                     beat_cnt <= '0;
                  end else begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
               end
            end
         endcase
      end
   end

   mux #(
      .BIT_WIDTH(BIT_WIDTH),
      .DEPTH    (DEPTH),
      .SEL_WIDTH(SEL_WIDTH)
   ) u_mux (
      .dataIn(dataIn),
      .select(select),
      .muxout(muxout)
   );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios then random traffic, scored
// against a transaction-level round-robin model kept in plain integers.

module tb_mux_rr_arbiter;

   localparam int BW = 4;
   localparam int D  = 4;
   localparam int SW = 2;
   localparam int BL = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [D-1:0]  reqValid;
   logic [D-1:0]  reqReady;
   logic [BW*D-1:0] dataIn;
   logic          outValid;
   logic          outReady;
   logic [BW-1:0] muxout;
   logic [SW-1:0] select;
   logic          busy;

   mux_rr_arbiter #(
      .BIT_WIDTH(BW), .DEPTH(D), .SEL_WIDTH(SW), .BURST_LEN(BL)
   ) dut (
      .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady),
      .dataIn(dataIn), .outValid(outValid), .outReady(outReady),
      .muxout(muxout), .select(select), .busy(busy)
   );

   // clock / reset
   always #5 clk = ~clk;

   typedef struct packed {
      logic          v;
      logic          b;
      logic [SW-1:0] s;
   } ctl_t;

   ctl_t                ctl_q[$];
   logic [SW+BW-1:0]    exp_q[$];
   int                  checks = 0;
   int                  passed = 0;
   bit                  rand_mode = 1'b0;
   logic [D-1:0]        acc_mask = '0;

   task automatic check(input bit ok, input string name, input string detail);
      checks++;
      if (ok) passed++;
      else $display("FAIL %s: %s", name, detail);
   endtask

   // Reference model: who owns the mux, next-priority index, beats taken.
   int m_owner = -1;
   int m_sel   = 0;
   int m_ptr   = 0;
   int m_beats = 0;

   always @(negedge clk) begin
      ctl_t c;
      bit   valid_now;
      valid_now = !rst && (m_owner >= 0) && reqValid[m_sel];
      c.v = valid_now;
      c.b = (m_owner >= 0);
      c.s = SW'(m_sel);
      ctl_q.push_back(c);
      if (valid_now && outReady)
         exp_q.push_back({SW'(m_sel), dataIn[m_sel*BW +: BW]});
      if (rst) begin
         m_owner = -1; m_sel = 0; m_ptr = 0; m_beats = 0;
      end else if (m_owner < 0) begin
         for (int k = 0; k < D; k++) begin
            if (m_owner < 0 && reqValid[(m_ptr + k) % D]) begin
               m_owner = (m_ptr + k) % D;
               m_sel   = m_owner;
               m_beats = 0;
            end
         end
      end else if (!reqValid[m_sel]) begin
         m_owner = -1; m_ptr = (m_sel + 1) % D; m_beats = 0;
      end else if (outReady) begin
         m_beats++;
         if (m_beats == BL) begin
            m_owner = -1; m_ptr = (m_sel + 1) % D; m_beats = 0;
         end
      end
   end

   // Monitor: control every cycle, data on every DUT transfer.
   always @(negedge clk) begin
      #1;
      acc_mask = reqReady;
      if (ctl_q.size() > 0) begin
         ctl_t c;
         c = ctl_q.pop_front();
         check(outValid === c.v && busy === c.b && select === c.s, "ctl",
               $sformatf("got v=%b b=%b s=%0d want v=%b b=%b s=%0d",
                         outValid, busy, select, c.v, c.b, c.s));
      end
      if (outValid === 1'b1 && outReady === 1'b1) begin
         if (exp_q.size() == 0) begin
            check(1'b0, "beat", $sformatf("unexpected beat sel=%0d data=%h", select, muxout));
         end else begin
            logic [SW+BW-1:0] e;
            e = exp_q.pop_front();
            check({select, muxout} === e, "beat",
                  $sformatf("got sel=%0d data=%h want sel=%0d data=%h",
                            select, muxout, e[SW+BW-1:BW], e[BW-1:0]));
            check(reqReady === (D'(1) << e[SW+BW-1:BW]), "ready_onehot",
                  $sformatf("got %b want bit %0d", reqReady, e[SW+BW-1:BW]));
         end
      end else begin
         check(reqReady === '0, "ready_idle", $sformatf("got %b want 0", reqReady));
      end
   end

   // Driver: advance one cycle, then update inputs when in random mode.
   task automatic step();
      @(posedge clk);
      #1;
      if (rand_mode) begin
         for (int i = 0; i < D; i++) begin
            if (acc_mask[i]) begin
               dataIn[i*BW +: BW] = BW'($urandom_range(0, (1 << BW) - 1));
               reqValid[i] = ($urandom_range(0, 3) != 0);
            end else if (!reqValid[i]) begin
               if ($urandom_range(0, 1) == 1) begin
                  reqValid[i] = 1'b1;
                  dataIn[i*BW +: BW] = BW'($urandom_range(0, (1 << BW) - 1));
               end
            end else if ($urandom_range(0, 15) == 0) begin
               reqValid[i] = 1'b0;
            end
         end
         outReady = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 199) == 0);
      end
   endtask

   task automatic run(input logic [D-1:0] v, input logic r, input int n);
      reqValid = v;
      outReady = r;
      repeat (n) step();
   endtask

   initial begin
      rst = 1'b1; reqValid = '0; dataIn = 16'h1B2C; outReady = 1'b0;
      step();
      rst = 1'b0;
      run(4'b0000, 1'b0, 5);
      run(4'b0100, 1'b1, 8);
      run(4'b0000, 1'b1, 2);
      dataIn = 16'h4D7A;
      run(4'b1111, 1'b1, 16);
      run(4'b0000, 1'b1, 2);
      run(4'b0010, 1'b0, 4);
      run(4'b0010, 1'b1, 4);
      run(4'b0000, 1'b1, 2);
      run(4'b1000, 1'b1, 2);
      run(4'b0010, 1'b1, 1);
      run(4'b1010, 1'b1, 4);
      run(4'b1111, 1'b1, 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      run(4'b1111, 1'b1, 6);
      rand_mode = 1'b1;
      repeat (600) step();
      rand_mode = 1'b0;
      rst = 1'b0;
      run(4'b0000, 1'b1, 4);
      check(exp_q.size() == 0, "drain", $sformatf("%0d beats never seen", exp_q.size()));
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
